uart_transmitter: RTL and testbench

- UART serial transmitter. It is the transmit counterpart of the team's 16x-oversampled UART receiver.
- Runs on the same baud_clk, at OVERSAMPLE ticks per bit.
- Accepts parallel words through a valid/ready handshake and serialises them LSB-first as start, data, optional parity and stop bits.
- A one-word holding register lets the next word queue while the current frame shifts out, so consecutive frames go out back-to-back.

---
 rtl/uart_transmitter_if.sv | 12 +
 rtl/uart_transmitter.sv | 159 +++++++++++++++
 tb/tb_uart_transmitter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_transmitter_if.sv
// Parallel word handshake into the UART transmitter.
// master drives tx_data/tx_valid; slave (the transmitter) returns tx_ready.
interface uart_transmitter_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_transmitter.sv
// UART serial transmitter running on the oversampled baud_clk.
// Frames are start, DATA_BITS data bits LSB-first, optional parity and
// STOP_BITS stop bits. A one-word holding register lets the next word queue
// while the current frame shifts out, so frames can go out back-to-back.
module uart_transmitter #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                  baud_clk,
  input  logic                  reset,
  uart_transmitter_if.slave     tx_if,
  output logic                  uart_tx,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int unsigned TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] TICK_PRE  = TICK_W'(OVERSAMPLE - 2);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic              ODD_FLIP  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state;
  logic [DATA_BITS-1:0] hold_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 hold_full;
  logic                 tx_ready_q;
  logic                 parity_bit;
  logic [TICK_W-1:0]    tick;
  logic [BIT_W-1:0]     bit_cnt;

  logic accept;
  logic bit_end;
  logic frame_end;
  logic load;
  logic hold_full_d;

  assign tx_if.tx_ready = tx_ready_q;

  // Handshake, bit-boundary and hold->shift transfer decisions.
  always_comb begin
    accept      = tx_if.tx_valid & tx_ready_q;
    bit_end     = (tick == TICK_LAST);
    frame_end   = (state == STOP) && bit_end && (bit_cnt == STOP_LAST);
    load        = hold_full && ((state == IDLE) || frame_end);
    hold_full_d = hold_full;
    if (load) begin
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_full_d = 1'b1;
    end
  end

  // Holding register; tx_ready follows the next-state fullness so a word
  // cannot be accepted on the same edge the register is being drained.
  always_ff @(posedge baud_clk or negedge reset) begin
    if (!reset) begin
      hold_reg   <= '0;
      hold_full  <= 1'b0;
      tx_ready_q <= 1'b1;
    end else begin
      hold_full  <= hold_full_d;
      tx_ready_q <= ~hold_full_d;
      if (accept) begin
        hold_reg <= tx_if.tx_data;
      end
    end
  end

  // Frame FSM with registered line, busy and done outputs.
  always_ff @(posedge baud_clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      tick       <= '0;
      bit_cnt    <= '0;
      uart_tx    <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      // Raised one edge early so the pulse covers the final stop tick itself.
      tx_done <= (state == STOP) && (tick == TICK_PRE) && (bit_cnt == STOP_LAST);

      if (load) begin
        shift_reg  <= hold_reg;
        parity_bit <= (^hold_reg) ^ ODD_FLIP;
        tick       <= '0;
        bit_cnt    <= '0;
        state      <= START;
        uart_tx    <= 1'b0;
        tx_busy    <= 1'b1;
      end else if (state != IDLE) begin
        tick <= bit_end ? '0 : tick + 1'b1;
        if (bit_end) begin
          case (state)
            START: begin
              state   <= DATA;
              bit_cnt <= '0;
              uart_tx <= shift_reg[0];
            end
            DATA: begin
              shift_reg <= shift_reg >> 1;
              if (bit_cnt == DATA_LAST) begin
                bit_cnt <= '0;
                if (PARITY_EN != 0) begin
                  state   <= PARITY;
                  uart_tx <= parity_bit;
                end else begin
                  state   <= STOP;
                  uart_tx <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                uart_tx <= shift_reg[1];
              end
            end
            PARITY: begin
              state   <= STOP;
              bit_cnt <= '0;
              uart_tx <= 1'b1;
            end
            STOP: begin
              uart_tx <= 1'b1;
              if (bit_cnt == STOP_LAST) begin
                state   <= IDLE;
                bit_cnt <= '0;
                tx_busy <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
            default: begin
              state   <= IDLE;
              uart_tx <= 1'b1;
              tx_busy <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: four instances cover 8N1, even and
// odd parity, and two stop bits; every line cycle of each frame is compared
// against a bit sequence built here from the word and frame format.
module tb_uart_transmitter;

  logic baud_clk = 1'b0;
  logic reset;

  always #5 baud_clk = ~baud_clk;

  uart_transmitter_if #(.DATA_BITS(8)) if0 ();
  uart_transmitter_if #(.DATA_BITS(8)) if1 ();
  uart_transmitter_if #(.DATA_BITS(8)) if2 ();
  uart_transmitter_if #(.DATA_BITS(8)) if3 ();

  logic tx0, tx1, tx2, tx3;
  logic busy0, busy1, busy2, busy3;
  logic done0, done1, done2, done3;

  uart_transmitter #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    dut0 (.baud_clk(baud_clk), .reset(reset), .tx_if(if0), .uart_tx(tx0), .tx_busy(busy0), .tx_done(done0));
  uart_transmitter #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    dut1 (.baud_clk(baud_clk), .reset(reset), .tx_if(if1), .uart_tx(tx1), .tx_busy(busy1), .tx_done(done1));
  uart_transmitter #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
    dut2 (.baud_clk(baud_clk), .reset(reset), .tx_if(if2), .uart_tx(tx2), .tx_busy(busy2), .tx_done(done2));
  uart_transmitter #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
    dut3 (.baud_clk(baud_clk), .reset(reset), .tx_if(if3), .uart_tx(tx3), .tx_busy(busy3), .tx_done(done3));

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic cur_line(input int s);
    case (s)
      0: return tx0;
      1: return tx1;
      2: return tx2;
      default: return tx3;
    endcase
  endfunction

  function automatic logic cur_busy(input int s);
    case (s)
      0: return busy0;
      1: return busy1;
      2: return busy2;
      default: return busy3;
    endcase
  endfunction

  function automatic logic cur_done(input int s);
    case (s)
      0: return done0;
      1: return done1;
      2: return done2;
      default: return done3;
    endcase
  endfunction

  function automatic logic cur_ready(input int s);
    case (s)
      0: return if0.tx_ready;
      1: return if1.tx_ready;
      2: return if2.tx_ready;
      default: return if3.tx_ready;
    endcase
  endfunction

  task automatic drive(input int s, input logic [7:0] d, input logic v);
    case (s)
      0: begin if0.tx_data = d; if0.tx_valid = v; end
      1: begin if1.tx_data = d; if1.tx_valid = v; end
      2: begin if2.tx_data = d; if2.tx_valid = v; end
      default: begin if3.tx_data = d; if3.tx_valid = v; end
    endcase
  endtask

  // Called #1 after an edge; waits (bounded) for ready, then presents the
  // word for exactly one edge. Returns #1 after the accept edge.
  task automatic send(input int s, input logic [7:0] d, input string tag);
    int n = 0;
    while (cur_ready(s) !== 1'b1 && n < 1000) begin
      @(posedge baud_clk); #1;
      n++;
    end
    check({tag, "_rdy"}, 32'(cur_ready(s)), 32'd1);
    drive(s, d, 1'b1);
    @(posedge baud_clk); #1;
    drive(s, d, 1'b0);
  endtask

  // Called #1 after edge M; the frame's first start cycle begins at edge M+1.
  task automatic check_frame(input int s, input logic [7:0] d, input int pen, input int podd,
                             input int nstop, input bit last, input string tag);
    logic exp_bits[12];
    int   match[12];
    int   nb;
    int   len;
    int   done_cnt = 0;
    int   done_pos = -1;
    int   busy_cnt = 0;
    logic pbit;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[1 + i] = d[i];
    nb = 9;
    if (pen != 0) begin
      pbit = (^d) ^ podd[0];
      exp_bits[nb] = pbit;
      nb++;
    end
    for (int j = 0; j < nstop; j++) begin
      exp_bits[nb] = 1'b1;
      nb++;
    end
    for (int k = 0; k < 12; k++) match[k] = 0;
    len = nb * 16;
    for (int c = 1; c <= len; c++) begin
      @(posedge baud_clk); #1;
      if (cur_line(s) === exp_bits[(c - 1) / 16]) match[(c - 1) / 16]++;
      if (cur_done(s) === 1'b1) begin
        done_cnt++;
        done_pos = c;
      end
      if (cur_busy(s) === 1'b1) busy_cnt++;
    end
    for (int k = 0; k < nb; k++)
      check($sformatf("%s_bit%0d_cycles", tag, k), 32'(match[k]), 32'd16);
    check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    check({tag, "_done_cycle"}, 32'(done_pos), 32'(len));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(len));
    if (last) begin
      @(posedge baud_clk); #1;
      check({tag, "_busy_after"}, 32'(cur_busy(s)), 32'd0);
      check({tag, "_line_after"}, 32'(cur_line(s)), 32'd1);
      check({tag, "_done_after"}, 32'(cur_done(s)), 32'd0);
    end
  endtask

  initial begin
    for (int s = 0; s < 4; s++) drive(s, 8'h00, 1'b0);
    reset = 1'b0;
    #23;
    check("rst_line", 32'(tx0), 32'd1);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_ready", 32'(if0.tx_ready), 32'd1);
    @(negedge baud_clk);
    reset = 1'b1;
    @(posedge baud_clk); #1;

    // 8N1 single frame; line must still be idle right after the accept edge.
    send(0, 8'h55, "t1");
    check("t1_line_at_accept", 32'(tx0), 32'd1);
    check("t1_ready_low", 32'(if0.tx_ready), 32'd0);
    check_frame(0, 8'h55, 0, 0, 1, 1'b1, "t1");

    // Back-to-back frames, second word offered as soon as ready returns.
    send(0, 8'hA5, "t2a");
    fork
      begin
        check_frame(0, 8'hA5, 0, 0, 1, 1'b0, "t2a");
        check_frame(0, 8'h3C, 0, 0, 1, 1'b1, "t2b");
      end
      send(0, 8'h3C, "t2b");
    join

    // Even then odd parity on 0x07.
    send(1, 8'h07, "t3e");
    check_frame(1, 8'h07, 1, 0, 1, 1'b1, "t3e");
    send(2, 8'h07, "t3o");
    check_frame(2, 8'h07, 1, 1, 1, 1'b1, "t3o");

    // Two stop bits.
    send(3, 8'hFF, "t4");
    check_frame(3, 8'hFF, 0, 0, 2, 1'b1, "t4");

    // tx_valid held high across three words; only one accept per ready window.
    drive(0, 8'h11, 1'b1);
    @(posedge baud_clk); #1;
    fork
      begin
        check_frame(0, 8'h11, 0, 0, 1, 1'b0, "t5a");
        check_frame(0, 8'h22, 0, 0, 1, 1'b0, "t5b");
        check_frame(0, 8'h33, 0, 0, 1, 1'b1, "t5c");
      end
      begin
        logic [7:0] words[2];
        words[0] = 8'h22;
        words[1] = 8'h33;
        for (int w = 0; w < 2; w++) begin
          int n = 0;
          drive(0, words[w], 1'b1);
          while (if0.tx_ready !== 1'b1 && n < 400) begin
            @(posedge baud_clk); #1;
            n++;
          end
          check($sformatf("t5_ready_%0d", w), 32'(if0.tx_ready), 32'd1);
          @(posedge baud_clk); #1;
        end
        drive(0, 8'h00, 1'b0);
      end
    join

    // Reset in the middle of the data bits, then a clean frame.
    send(0, 8'hC3, "t6_old");
    repeat (70) @(posedge baud_clk);
    #3;
    reset = 1'b0;
    #1;
    check("t6_rst_line", 32'(tx0), 32'd1);
    check("t6_rst_busy", 32'(busy0), 32'd0);
    check("t6_rst_ready", 32'(if0.tx_ready), 32'd1);
    check("t6_rst_done", 32'(done0), 32'd0);
    @(negedge baud_clk);
    reset = 1'b1;
    @(posedge baud_clk); #1;
    check("t6_idle_line", 32'(tx0), 32'd1);
    check("t6_idle_busy", 32'(busy0), 32'd0);
    send(0, 8'h81, "t6");
    check_frame(0, 8'h81, 0, 0, 1, 1'b1, "t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
